// File: rtl/mips_key_pkg.sv
// rtl/mips_key_pkg.sv - shared state encoding and counter sizing for the key debouncer
package mips_key_pkg;

    typedef enum logic [1:0] {
        KS_IDLE        = 2'd0,
        KS_DEB_PRESS   = 2'd1,
        KS_HELD        = 2'd2,
        KS_DEB_RELEASE = 2'd3
    } key_state_t;

    // One spare bit so the hold counter can park at LONG_CYCLES without wrapping.
    function automatic int cnt_width(input int deb, input int lng);
        int m;
        m = (deb > lng) ? deb : lng;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mips_key_chan.sv
// rtl/mips_key_chan.sv - one key channel: synchroniser, debounce FSM, hold counter, event pulses
module mips_key_chan
    import mips_key_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 1024,
    parameter int ACTIVE_HIGH = 1,
    parameter int CW          = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_hit
);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          pressed_in;
    key_state_t    state;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] hold_cnt;

    assign pressed_in = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            state    <= KS_IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            rel      <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            sync1    <= key_in;
            sync2    <= sync1;
            press    <= 1'b0;
            rel      <= 1'b0;
            long_hit <= 1'b0;
            case (state)
                KS_IDLE: begin
                    if (pressed_in) begin
                        state   <= KS_DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end
                KS_DEB_PRESS: begin
                    if (!pressed_in) begin
                        state <= KS_IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= KS_HELD;
                        level    <= 1'b1;
                        press    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                KS_HELD: begin
                    // hold_cnt is left untouched on the way out so a bounce back resumes it
                    if (!pressed_in) begin
                        state   <= KS_DEB_RELEASE;
                        deb_cnt <= '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        long_hit <= 1'b1;
                        hold_cnt <= LONG_SAT;
                    end else if (hold_cnt < LONG_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                KS_DEB_RELEASE: begin
                    if (pressed_in) begin
                        state <= KS_HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state <= KS_IDLE;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_key_debounce.sv
// rtl/mips_key_debounce.sv - multi-channel key debouncer with sticky event flags and interrupt
module mips_key_debounce
    import mips_key_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 1024,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] ev_clr,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] ev_pending,
    output logic              irq
);

    localparam int CW = cnt_width(DEB_CYCLES, LONG_CYCLES);

    generate
        if (DEB_CYCLES < 1 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_params
            $error("mips_key_debounce: need DEB_CYCLES >= 1 and LONG_CYCLES > DEB_CYCLES");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < N_KEYS; i++) begin : g_chan
            mips_key_chan #(
                .DEB_CYCLES (DEB_CYCLES),
                .LONG_CYCLES(LONG_CYCLES),
                .ACTIVE_HIGH(ACTIVE_HIGH),
                .CW         (CW)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .key_in  (key_in[i]),
                .level   (key_level[i]),
                .press   (key_press[i]),
                .rel     (key_release[i]),
                .long_hit(key_long[i])
            );
        end
    endgenerate

    // A new event outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_pending <= '0;
            irq        <= 1'b0;
        end else begin
            ev_pending <= (ev_pending & ~ev_clr) | key_press | key_release | key_long;
            irq        <= |ev_pending;
        end
    end

endmodule

// File: tb/tb_mips_key_debounce.sv
// tb/tb_mips_key_debounce.sv - randomized and directed bench for mips_key_debounce against a run-length model
module tb_mips_key_debounce;

    localparam int NK   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] ev_clr = '0;
    logic [NK-1:0] key_level, key_press, key_release, key_long, ev_pending;
    logic          irq;

    mips_key_debounce #(
        .N_KEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_HIGH(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .ev_clr(ev_clr),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .ev_pending(ev_pending), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int base   = 0;
    bit chk_en = 1'b0;

    // Model: a level flips after DEB+1 consecutive opposite samples seen two flops late.
    logic [NK-1:0] m_p1 = '0, m_p2 = '0;
    logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0, m_pend = '0;
    logic          m_irq = 1'b0;
    int            m_run[NK];
    int            m_hold[NK];

    always @(posedge clk) begin
        edges++;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            m_long = '0; m_pend = '0; m_irq = 1'b0;
            for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
        end else begin
            m_irq = (m_pend != 0);
            for (int k = 0; k < NK; k++) begin
                if (m_press[k] || m_rel[k] || m_long[k]) m_pend[k] = 1'b1;
                else if (ev_clr[k])                      m_pend[k] = 1'b0;
            end
            m_press = '0; m_rel = '0; m_long = '0;
            for (int k = 0; k < NK; k++) begin
                if (m_p2[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB + 1) begin
                        m_run[k] = 0;
                        m_level[k] = ~m_level[k];
                        if (m_level[k]) begin m_press[k] = 1'b1; m_hold[k] = 0; end
                        else m_rel[k] = 1'b1;
                    end
                end else begin
                    if (m_level[k] && m_run[k] == 0) begin
                        if (m_hold[k] == LONG - 1) m_long[k] = 1'b1;
                        m_hold[k]++;
                    end
                    m_run[k] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = key_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("key_level",   32'(key_level),   32'(m_level));
            chk("key_press",   32'(key_press),   32'(m_press));
            chk("key_release", 32'(key_release), 32'(m_rel));
            chk("key_long",    32'(key_long),    32'(m_long));
            chk("ev_pending",  32'(ev_pending),  32'(m_pend));
            chk("irq",         32'(irq),         32'(m_irq));
        end
    end

    task automatic mark();
        base = edges;
    endtask

    task automatic at(input int k);
        while (edges < base + k + 1) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold_left[NK];

    initial begin
        ticks(1);
        chk_en = 1'b1;
        key_in = 2'b11;
        ticks(3);
        chk("reset outputs", {key_level, key_press, key_release, key_long, ev_pending, 3'b000, irq}, 32'd0);
        key_in = '0;
        rst = 1'b0;
        ticks(3);

        // Clean press, long press, release with clear race on key 0
        mark(); key_in[0] = 1'b1;
        at(5);  chk("press latency early", 32'(key_press[0]), 32'd0);
        at(6);  chk("press at 6", 32'(key_press[0]), 32'd1);
                chk("level at 6", 32'(key_level[0]), 32'd1);
        at(7);  chk("pending at 7", 32'(ev_pending[0]), 32'd1);
                chk("irq at 7", 32'(irq), 32'd0);
        at(8);  chk("irq at 8", 32'(irq), 32'd1);
        at(25); chk("long before 26", 32'(key_long[0]), 32'd0);
        at(26); chk("long at 26", 32'(key_long[0]), 32'd1);
        at(27); chk("long single", 32'(key_long[0]), 32'd0);
                ev_clr[0] = 1'b1;
        at(28); chk("pending cleared", 32'(ev_pending[0]), 32'd0);
                ev_clr[0] = 1'b0;
        at(29); chk("irq dropped", 32'(irq), 32'd0);
        at(39); mark(); key_in[0] = 1'b0;
        at(5);  chk("release early", 32'(key_release[0]), 32'd0);
        at(6);  chk("release at 6", 32'(key_release[0]), 32'd1);
                chk("level cleared", 32'(key_level[0]), 32'd0);
                ev_clr[0] = 1'b1;
        at(7);  chk("set beats clear", 32'(ev_pending[0]), 32'd1);
        at(8);  chk("second clear", 32'(ev_pending[0]), 32'd0);
                chk("irq still high", 32'(irq), 32'd1);
                ev_clr[0] = 1'b0;
        at(9);  chk("irq follows clear", 32'(irq), 32'd0);
        ticks(4);

        // Release glitch while held, then reset mid-hold
        mark(); key_in[0] = 1'b1;
        at(6);  chk("glitch press", 32'(key_press[0]), 32'd1);
        at(9);  key_in[0] = 1'b0;
        at(11); key_in[0] = 1'b1;
        at(20); chk("level after glitch", 32'(key_level[0]), 32'd1);
                rst = 1'b1;
        for (int r = 21; r <= 23; r++) begin
            at(r);
            chk("outputs in reset", {key_level, key_press, key_release, key_long, ev_pending, 3'b000, irq}, 32'd0);
        end
        mark(); rst = 1'b0;
        at(5);  chk("post-reset early", 32'(key_press[0]), 32'd0);
        at(6);  chk("post-reset press", 32'(key_press[0]), 32'd1);
        at(10); key_in[0] = 1'b0;
        ticks(12);
        ev_clr = '1; ticks(2); ev_clr = '0; ticks(2);

        // Bounce on key 1
        for (int b = 0; b < 10; b++) begin
            key_in[1] = ~key_in[1];
            ticks(2);
        end
        key_in[1] = 1'b0;
        ticks(15);
        chk("bounce level", 32'(key_level[1]), 32'd0);
        chk("bounce irq", 32'(irq), 32'd0);
        chk("bounce pending", 32'(ev_pending), 32'd0);

        // Random phase
        for (int k = 0; k < NK; k++) hold_left[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold_left[k] == 0) begin
                    key_in[k] = 1'($urandom_range(0, 1));
                    hold_left[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                               : int'($urandom_range(5, 40));
                end
                hold_left[k]--;
            end
            ev_clr = ($urandom_range(0, 7) == 0) ? NK'($urandom) : '0;
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
            ticks(1);
        end
        rst = 1'b0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
